// File: rtl/fifo_sync.sv
// Single-clock FIFO with registered or first-word-fall-through read port,
// occupancy count, threshold flags and sticky overflow/underflow errors.
module fifo_sync #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 2,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] AF_T = AF_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_T = AE_THRESH[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr;
    logic                  wr_acc, rd_acc;

    // MSB is the wrap bit: equal low bits with differing wrap means full
    assign full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                   (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    assign almost_full  = (count >= AF_T);
    assign almost_empty = (count <= AE_T);

    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + ONE;
            if (rd_acc) rd_ptr <= rd_ptr + ONE;
            if (wr_acc && !rd_acc)
                count <= count + ONE;
            else if (rd_acc && !wr_acc)
                count <= count - ONE;
            // a new error event in the clearing cycle keeps the flag set
            overflow  <= (wr_en & full)  | (overflow  & ~clr_err);
            underflow <= (rd_en & empty) | (underflow & ~clr_err);
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rd_data  = mem[rd_ptr[ADDR_WIDTH-1:0]];
            assign rd_valid = ~empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] rd_data_q;
            logic                  rd_valid_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc)
                        rd_data_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
                end
            end
            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end
    endgenerate
endmodule

// File: tb/tb_fifo_sync.sv
// Drives a registered-read and a fall-through FIFO with identical stimulus and
// checks both against a queue-based reference model every cycle.
module tb_fifo_sync;
    logic       clk = 1'b0;
    logic       rst, wr_en, rd_en, clr_err;
    logic [7:0] wr_data;

    logic [7:0] rd_data0, rd_data1;
    logic       rd_valid0, rd_valid1;
    logic       full0, empty0, af0, ae0, ovf0, unf0;
    logic       full1, empty1, af1, ae1, ovf1, unf1;
    logic [4:0] count0, count1;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fifo_sync #(.FWFT(0)) u_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data0), .rd_valid(rd_valid0), .full(full0), .empty(empty0),
        .almost_full(af0), .almost_empty(ae0), .count(count0),
        .overflow(ovf0), .underflow(unf0), .clr_err(clr_err)
    );

    fifo_sync #(.FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .count(count1),
        .overflow(ovf1), .underflow(unf1), .clr_err(clr_err)
    );

    // reference model state
    logic [7:0] q[$];
    logic [7:0] m_rd;
    logic       m_vld, m_ovf, m_unf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        int sz;
        sz = q.size();
        chk("count0", 32'(count0), 32'(sz));
        chk("count1", 32'(count1), 32'(sz));
        chk("full0",  32'(full0),  32'(sz == 16));
        chk("empty0", 32'(empty0), 32'(sz == 0));
        chk("af0",    32'(af0),    32'(sz >= 14));
        chk("ae0",    32'(ae0),    32'(sz <= 2));
        chk("full1",  32'(full1),  32'(sz == 16));
        chk("empty1", 32'(empty1), 32'(sz == 0));
        chk("ovf0",   32'(ovf0),   32'(m_ovf));
        chk("unf0",   32'(unf0),   32'(m_unf));
        chk("ovf1",   32'(ovf1),   32'(m_ovf));
        chk("unf1",   32'(unf1),   32'(m_unf));
        chk("vld0",   32'(rd_valid0), 32'(m_vld));
        chk("rdat0",  32'(rd_data0),  32'(m_rd));
        chk("vld1",   32'(rd_valid1), 32'(sz != 0));
        if (sz != 0) chk("rdat1", 32'(rd_data1), 32'(q[0]));
    endtask

    // apply one cycle of stimulus, advance the model, then compare
    task automatic step(input logic we, input logic re, input logic [7:0] wd,
                        input logic clr, input logic r);
        bit was_full, was_empty;
        wr_en = we; rd_en = re; wr_data = wd; clr_err = clr; rst = r;
        @(posedge clk);
        if (r) begin
            q.delete();
            m_rd = 8'h00; m_vld = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            was_full  = (q.size() == 16);
            was_empty = (q.size() == 0);
            m_ovf = (we && was_full)  || (m_ovf && !clr);
            m_unf = (re && was_empty) || (m_unf && !clr);
            m_vld = re && !was_empty;
            if (m_vld) m_rd = q.pop_front();
            if (we && !was_full) q.push_back(wd);
        end
        #1;
        check_all();
    endtask

    initial begin
        m_rd = 8'h00; m_vld = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        step(0, 0, 8'h00, 0, 1);
        step(1, 1, 8'h33, 0, 1);
        chk("rst_empty", 32'(empty0), 32'd1);
        chk("rst_ae",    32'(ae0),    32'd1);

        // fill, overflow, drain
        for (int i = 0; i < 16; i++) step(1, 0, 8'(i), 0, 0);
        chk("fill_full",  32'(full0),  32'd1);
        chk("fill_count", 32'(count0), 32'd16);
        step(1, 0, 8'hEE, 0, 0);
        chk("ovf_set", 32'(ovf0), 32'd1);
        step(0, 0, 8'h00, 1, 0);
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 8'h00, 0, 0);
            chk("drain_data", 32'(rd_data0), 32'(i));
        end
        step(0, 0, 8'h00, 0, 0);
        chk("drain_empty", 32'(empty0), 32'd1);

        // simultaneous push/pop at full and at empty
        for (int i = 0; i < 16; i++) step(1, 0, 8'(8'h40 + i), 0, 0);
        step(1, 1, 8'h99, 0, 0);
        chk("both_full_cnt", 32'(count0), 32'd15);
        chk("both_full_flag", 32'(full0), 32'd0);
        for (int i = 0; i < 15; i++) step(0, 1, 8'h00, 0, 0);
        step(1, 1, 8'h5C, 0, 0);
        chk("both_empty_cnt", 32'(count0), 32'd1);
        chk("both_empty_vld", 32'(rd_valid0), 32'd0);
        step(0, 1, 8'h00, 0, 0);
        chk("both_empty_rd", 32'(rd_data0), 32'h5C);

        // sticky underflow
        step(0, 1, 8'h00, 0, 0);
        chk("unf_set", 32'(unf0), 32'd1);
        step(0, 0, 8'h00, 0, 0);
        step(0, 1, 8'h00, 1, 0);
        chk("unf_set_wins", 32'(unf0), 32'd1);
        step(0, 0, 8'h00, 1, 0);
        chk("unf_clr", 32'(unf0), 32'd0);

        // fall-through head visible without rd_en
        step(1, 0, 8'hA5, 0, 0);
        chk("fwft_vld",  32'(rd_valid1), 32'd1);
        chk("fwft_data", 32'(rd_data1),  32'hA5);
        step(0, 1, 8'h00, 0, 0);
        chk("fwft_pop_empty", 32'(empty1),   32'd1);
        chk("fwft_pop_vld",   32'(rd_valid1), 32'd0);

        // random interleave, biased to push so the pointers wrap
        for (int i = 0; i < 40; i++)
            step(($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 45),
                 8'($urandom), ($urandom_range(0, 9) == 0), 0);

        // reset with contents held, requests ignored in reset cycle
        step(0, 0, 8'h00, 1, 0);
        while (q.size() > 0) step(0, 1, 8'h00, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 8'(8'hC0 + i), 0, 0);
        step(1, 1, 8'hFF, 0, 1);
        chk("rst_cnt",   32'(count0), 32'd0);
        chk("rst_empt",  32'(empty0), 32'd1);
        chk("rst_vld",   32'(rd_valid0), 32'd0);
        step(0, 0, 8'h00, 0, 0);
        chk("post_rst_af", 32'(af0), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/fifo_sync.md
FIFO_SYNC -- requirements
Module: fifo_sync

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, which sets the word width in bits.
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 4, with DEPTH = 2**ADDR_WIDTH words.
REQ-003 The module SHALL have parameter AF_THRESH, default DEPTH-2, giving the almost_full asserted level (count >= AF_THRESH).
REQ-004 The module SHALL have parameter AE_THRESH, default 2, giving the almost_empty asserted level (count <= AE_THRESH).
REQ-005 The module SHALL have parameter FWFT, default 0, where 0 selects standard registered-read mode and 1 selects first-word-fall-through mode.
REQ-006 The module SHALL have port clk, input, 1 bit: the single clock, all state updating on its rising edge.
REQ-007 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 The module SHALL have port wr_en, input, 1 bit: write request.
REQ-009 The module SHALL have port wr_data, input, DATA_WIDTH bits: write word.
REQ-010 The module SHALL have port rd_en, input, 1 bit: read/pop request.
REQ-011 The module SHALL have port rd_data, output, DATA_WIDTH bits: read word.
REQ-012 The module SHALL have port rd_valid, output, 1 bit: rd_data holds a valid word.
REQ-013 The module SHALL have ports full, empty, almost_full and almost_empty, each output, 1 bit: status flags.
REQ-014 The module SHALL have port count, output, ADDR_WIDTH+1 bits: current occupancy, 0..DEPTH.
REQ-015 The module SHALL have ports overflow and underflow, each output, 1 bit: sticky error flags.
REQ-016 The module SHALL have port clr_err, input, 1 bit: clears the sticky error flags.

Function
REQ-017 Binary write and read pointers SHALL be ADDR_WIDTH+1 bits wide, with the low ADDR_WIDTH bits addressing storage and the MSB acting as wrap bit.
REQ-018 full SHALL equal (wr MSB != rd MSB) and (low bits equal); empty SHALL equal (pointers identical); both SHALL be pure functions of the registered pointers.
REQ-019 A write SHALL be accepted iff wr_en & ~full; when accepted, mem[wr_ptr] <= wr_data and wr_ptr increments modulo 2**(ADDR_WIDTH+1).
REQ-020 A read SHALL be accepted iff rd_en & ~empty; when accepted, rd_ptr increments modulo 2**(ADDR_WIDTH+1).
REQ-021 count SHALL be registered: +1 on write-only, -1 on read-only, unchanged on both or neither; count SHALL always equal wr_ptr - rd_ptr.
REQ-022 With simultaneous requests while full, the read SHALL be accepted and the write rejected (count -> DEPTH-1).
REQ-023 With simultaneous requests while empty, the write SHALL be accepted and the read rejected (count -> 1); in FWFT=0 mode rd_valid SHALL stay 0.
REQ-024 With simultaneous requests otherwise, both SHALL be accepted and count SHALL be unchanged.
REQ-025 FWFT=0 mode: rd_data SHALL be registered and SHALL be loaded with mem[rd_ptr] on an accepted read; rd_valid SHALL be 1 in the cycle after an accepted read, else 0; rd_data SHALL hold its value when no read is accepted.
REQ-026 FWFT=1 mode: rd_data SHALL equal mem[rd_ptr] combinationally, rd_valid SHALL equal ~empty, and rd_en SHALL pop the head word.
REQ-027 A word written in cycle N SHALL be visible to reads no earlier than cycle N+1; there SHALL be no write-to-read bypass.
REQ-028 almost_full and almost_empty SHALL be derived from the registered count.
REQ-029 overflow SHALL set on wr_en & full, and underflow SHALL set on rd_en & empty.
REQ-030 Both error flags SHALL hold until clr_err or rst; if set and clr_err occur in the same cycle, set SHALL win.
REQ-031 Rejected requests SHALL alter no pointer, memory word or count.
REQ-032 Storage SHALL be a DEPTH x DATA_WIDTH register array and SHALL require no reset.

Reset
REQ-033 While rst=1 at a clock edge, the pointers, count, rd_valid, overflow, underflow and registered rd_data SHALL all become 0.
REQ-034 After reset, empty and almost_empty SHALL be 1, and full and almost_full SHALL be 0.
REQ-035 Reset asserted mid-operation SHALL discard all contents, and wr_en/rd_en SHALL be ignored in the reset cycle.
REQ-036 Memory contents after reset SHALL be don't-care and SHALL never be observable, since reads are blocked while empty.

Verification
REQ-037 Fill/drain, defaults, FWFT=0: write 16 words 0x00..0x0F -> full=1 and count=16 after the 16th edge; 17th write -> overflow=1 and contents unchanged; 16 reads -> 0x00..0x0F each with rd_valid one cycle later, then empty=1.
REQ-038 Simultaneous read/write at boundaries: full with rd_en=wr_en=1 -> count=15, full=0; empty with both asserted -> count=1, rd_valid=0, and the next read returns the written word.
REQ-039 Thresholds, AF_THRESH=14 and AE_THRESH=2: almost_full rises at count=14 and falls at 13; almost_empty is 1 at count=2 and 0 at count=3.
REQ-040 Sticky errors: rd_en on empty -> underflow=1 and persists; clr_err=1 together with a new underflow event -> underflow stays 1; clr_err alone -> 0.
REQ-041 FWFT=1: write 0xA5 -> next cycle rd_valid=1 and rd_data=0xA5 without rd_en; pop -> empty=1 and rd_valid=0.
REQ-042 Wrap and reset: 40 random interleaved push/pop cycles are checked against a reference queue with count=wr_ptr-rd_ptr every cycle; then rst with 5 words held -> count=0, empty=1, and flags cleared next cycle.
